// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and datapath helpers for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned N_REQ        = 8;
    localparam int unsigned SELW         = 3;
    localparam int unsigned CNTW         = 3;
    localparam int unsigned MAX_HOLD_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // 8:1 bit mux built as two 4:1 muxes followed by a 2:1 mux.
    function automatic logic mux8(input logic [N_REQ-1:0] a, input logic [SELW-1:0] s);
        logic [1:0] w_lvl;
        w_lvl[0] = a[{1'b0, s[1:0]}];
        w_lvl[1] = a[{1'b1, s[1:0]}];
        return w_lvl[s[2]];
    endfunction

    // One-hot encode a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SELW-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/data bus between requesters and the arbiter.
interface mux8_rr_arbiter_if;
    import mux8_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic [N_REQ-1:0] gnt;
    logic [SELW-1:0]  sel;
    logic             dout;
    logic             dout_valid;
    logic             busy;

    modport master (
        output req, din,
        input  gnt, sel, dout, dout_valid, busy
    );

    modport slave (
        input  req, din,
        output gnt, sel, dout, dout_valid, busy
    );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin picker: first set request at or after ptr, wrapping mod 8.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SELW-1:0]  i_ptr,
    output logic [SELW-1:0]  o_winner_c,
    output logic             o_any_c
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SELW-1:0]    w_ffs;

    // Rotate right by ptr so the search always starts at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[{1'b0, i_ptr} +: N_REQ];

    // Find first set bit of the rotated vector (lowest index wins).
    always_comb begin
        w_ffs = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) w_ffs = SELW'(i);
        end
    end

    // Undo the rotation; 3-bit addition wraps mod 8.
    assign o_winner_c = w_ffs + i_ptr;
    assign o_any_c    = |i_req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of the shared 8:1 bit mux, with capped bursts.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    mux8_rr_arbiter_if.slave         bus
);

    state_t           r_state, w_state_nxt;
    logic [SELW-1:0]  r_ptr,   w_ptr_nxt;
    logic [CNTW-1:0]  r_cnt,   w_cnt_nxt;
    logic [N_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [SELW-1:0]  r_sel,   w_sel_nxt;
    logic             r_dout,  w_dout_nxt;
    logic             r_dout_valid, w_dout_valid_nxt;

    logic [SELW-1:0]  w_pick_ptr;
    logic [SELW-1:0]  w_winner;
    logic             w_any;
    logic             w_beat;
    logic             w_last;
    logic             w_mux;

    // While granting, the search for the next owner starts just past the current one.
    assign w_pick_ptr = (r_state == ST_GRANT) ? (r_sel + SELW'(1)) : r_ptr;
    assign w_beat     = (r_state == ST_GRANT) && bus.req[r_sel];
    assign w_last     = (r_cnt == CNTW'(MAX_HOLD - 1));
    assign w_mux      = mux8(bus.din, r_sel);

    rr_pick8 u_pick (
        .i_req      (bus.req),
        .i_ptr      (w_pick_ptr),
        .o_winner_c (w_winner),
        .o_any_c    (w_any)
    );

    // Register all state and outputs; reset drops any in-flight burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_sel        <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gnt        <= w_gnt_nxt;
            r_sel        <= w_sel_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
        end
    end

    // Next-state: grant on request, count beats, release and re-pick without a bubble.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_cnt_nxt        = r_cnt;
        w_gnt_nxt        = r_gnt;
        w_sel_nxt        = r_sel;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = onehot(w_winner);
                    w_sel_nxt   = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_beat) begin
                    w_dout_nxt       = w_mux;
                    w_dout_valid_nxt = 1'b1;
                end
                if (!w_beat || w_last) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_any) begin
                        w_gnt_nxt = onehot(w_winner);
                        w_sel_nxt = w_winner;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end
        endcase
    end

    assign bus.gnt        = r_gnt;
    assign bus.sel        = r_sel;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with per-cycle invariant checks.
module tb_mux8_rr_arbiter;
    import mux8_rr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic pre_bit;
    logic [7:0] din_pat;

    mux8_rr_arbiter_if u_if ();

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Every cycle: gnt one-hot/zero, gnt[sel]==busy, dout equals the previous cycle's din[sel].
    initial begin
        forever begin
            @(negedge clk);
            pre_bit = u_if.din[u_if.sel];
            @(posedge clk);
            #1;
            if (rst === 1'b0) begin
                chk("inv_onehot0", 32'($onehot0(u_if.gnt)), 32'd1);
                chk("inv_gnt_sel_busy", 32'(u_if.gnt[u_if.sel]), 32'(u_if.busy));
                if (u_if.dout_valid) chk("inv_dout", 32'(u_if.dout), 32'(pre_bit));
            end
        end
    end

    initial begin
        din_pat    = 8'b10101101;
        rst        = 1'b1;
        u_if.req   = '0;
        u_if.din   = '0;
        #2;
        chk("rst_gnt",   32'(u_if.gnt), 32'h0);
        chk("rst_sel",   32'(u_if.sel), 32'h0);
        chk("rst_dout",  32'(u_if.dout), 32'h0);
        chk("rst_valid", 32'(u_if.dout_valid), 32'h0);
        chk("rst_busy",  32'(u_if.busy), 32'h0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_gnt",  32'(u_if.gnt), 32'h0);
        chk("idle_busy", 32'(u_if.busy), 32'h0);

        // T2: sole requester 2, capped bursts re-granted without a gap.
        u_if.din = din_pat;
        u_if.req = 8'h04;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t2_gnt", 32'(u_if.gnt), 32'h04);
            chk("t2_sel", 32'(u_if.sel), 32'd2);
            chk("t2_valid", 32'(u_if.dout_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) chk("t2_dout", 32'(u_if.dout), 32'd1);
        end
        u_if.req = 8'h00;
        step();
        chk("t2_end_gnt",   32'(u_if.gnt), 32'h0);
        chk("t2_end_busy",  32'(u_if.busy), 32'h0);
        chk("t2_end_valid", 32'(u_if.dout_valid), 32'h0);
        chk("t2_end_sel",   32'(u_if.sel), 32'd2);
        chk("t2_end_dout",  32'(u_if.dout), 32'd1);

        // T5: ptr is now 3, so requester 3 wins; dropping it hands over to 2 with no bubble.
        u_if.req = 8'h0C;
        step();
        chk("t5_gnt3", 32'(u_if.gnt), 32'h08);
        chk("t5_sel3", 32'(u_if.sel), 32'd3);
        step();
        chk("t5_v1", 32'(u_if.dout_valid), 32'd1);
        chk("t5_d1", 32'(u_if.dout), 32'd1);
        step();
        chk("t5_v2", 32'(u_if.dout_valid), 32'd1);
        u_if.req = 8'h04;
        step();
        chk("t5_gap_valid", 32'(u_if.dout_valid), 32'd0);
        chk("t5_gap_dout",  32'(u_if.dout), 32'd1);
        chk("t5_gnt2",      32'(u_if.gnt), 32'h04);
        chk("t5_sel2",      32'(u_if.sel), 32'd2);
        chk("t5_busy",      32'(u_if.busy), 32'd1);
        step();
        chk("t5_v3", 32'(u_if.dout_valid), 32'd1);
        chk("t5_d3", 32'(u_if.dout), 32'd1);
        u_if.req = 8'h00;
        step();
        chk("t5_idle", 32'(u_if.gnt), 32'h0);

        // T3: all requesting from ptr=0; each index holds exactly 4 cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        u_if.req = 8'hFF;
        for (int k = 0; k < 36; k++) begin
            step();
            chk("t3_sel", 32'(u_if.sel), 32'((k / 4) % 8));
            chk("t3_gnt", 32'(u_if.gnt), 32'(8'h01 << ((k / 4) % 8)));
            if (k >= 1) begin
                chk("t3_valid", 32'(u_if.dout_valid), 32'd1);
                chk("t3_dout", 32'(u_if.dout), 32'(din_pat[((k - 1) / 4) % 8]));
            end
        end

        // T1: asynchronous reset mid-burst, observed before any clock edge.
        chk("t1_pre_busy", 32'(u_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_gnt",   32'(u_if.gnt), 32'h0);
        chk("t1_sel",   32'(u_if.sel), 32'h0);
        chk("t1_valid", 32'(u_if.dout_valid), 32'h0);
        chk("t1_busy",  32'(u_if.busy), 32'h0);
        chk("t1_dout",  32'(u_if.dout), 32'h0);

        // T6: recovery with requesters 0 and 7 alternating.
        u_if.req = 8'h81;
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("t6_sel", 32'(u_if.sel), (k >= 5 && k <= 8) ? 32'd7 : 32'd0);
            chk("t6_gnt", 32'(u_if.gnt), (k >= 5 && k <= 8) ? 32'h80 : 32'h01);
        end

        // T4: after granting 5, requesters 6 and 0 -> 6 for 4 beats, then wrap to 0.
        rst = 1'b1;
        u_if.req = 8'h00;
        step();
        rst = 1'b0;
        step();
        u_if.req = 8'h20;
        step();
        chk("t4_gnt5", 32'(u_if.gnt), 32'h20);
        chk("t4_sel5", 32'(u_if.sel), 32'd5);
        u_if.req = 8'h41;
        step();
        chk("t4_gnt6",   32'(u_if.gnt), 32'h40);
        chk("t4_sel6",   32'(u_if.sel), 32'd6);
        chk("t4_valid0", 32'(u_if.dout_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_sel", 32'(u_if.sel), 32'd6);
            chk("t4_hold_valid", 32'(u_if.dout_valid), 32'd1);
            chk("t4_hold_dout", 32'(u_if.dout), 32'd0);
        end
        step();
        chk("t4_wrap_gnt",   32'(u_if.gnt), 32'h01);
        chk("t4_wrap_sel",   32'(u_if.sel), 32'd0);
        chk("t4_wrap_busy",  32'(u_if.busy), 32'd1);
        chk("t4_wrap_valid", 32'(u_if.dout_valid), 32'd1);
        chk("t4_wrap_dout",  32'(u_if.dout), 32'd0);
        step();
        chk("t4_d0_valid", 32'(u_if.dout_valid), 32'd1);
        chk("t4_d0", 32'(u_if.dout), 32'd1);

        u_if.req = 8'h00;
        step();
        step();
        chk("final_idle", 32'(u_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
